// File: rtl/task_8_result_serializer.sv
// Buffers 128-bit butterfly results in a small FIFO and streams each one out
// MSB-first as 16 bytes over a valid/ready byte interface, with packet framing.
module task_8_result_serializer #(
    parameter int unsigned FIFO_DEPTH         = 2,
    parameter int unsigned RESULTS_PER_PACKET = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_A_re,
    input  logic [31:0] i_A_im,
    input  logic [31:0] i_B_re,
    input  logic [31:0] i_B_im,
    output logic        o_ready,
    output logic [7:0]  o_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_last,
    output logic        o_busy,
    output logic        o_overflow
);

    localparam int unsigned      PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned      CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]       LAST_RES = 8'(RESULTS_PER_PACKET - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t state, state_next;

    logic [127:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_next;
    logic [3:0]       byte_idx;
    logic [7:0]       res_cnt;
    logic             ready_q;
    logic             overflow_q;
    logic             push, pop, xfer;
    logic [127:0]     head_shifted;

    assign push = i_valid & ready_q;
    assign xfer = o_valid & i_ready;
    assign pop  = xfer & (byte_idx == 4'd15);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (push) state_next = SEND;
            SEND:    if (pop && (count_next == '0)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            byte_idx   <= '0;
            res_cnt    <= '0;
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count   <= count_next;
            ready_q <= (count_next != FULL_CNT);
            if (i_valid && !ready_q) overflow_q <= 1'b1;
            // byte_idx wraps 15 -> 0 on its own, which is exactly the pop edge
            if (xfer) begin
                byte_idx <= byte_idx + 4'd1;
                if (pop) res_cnt <= (res_cnt == LAST_RES) ? '0 : res_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push && !i_rst) mem[wr_ptr] <= {i_A_re, i_A_im, i_B_re, i_B_im};
    end

    assign head_shifted = mem[rd_ptr] << {byte_idx, 3'b000};

    always_comb begin
        o_valid    = (state == SEND);
        o_data     = o_valid ? head_shifted[127:120] : 8'h00;
        o_last     = o_valid && (byte_idx == 4'd15) && (res_cnt == LAST_RES);
        o_busy     = (count != '0) || o_valid;
        o_ready    = ready_q;
        o_overflow = overflow_q;
    end

endmodule

// File: tb/tb_task_8_result_serializer.sv
// Directed and random stimulus for the result serializer, checked every cycle
// against a queue-based reference model (one default instance, one with 3-result packets).
module tb_task_8_result_serializer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst, vin, rdy;
    logic [31:0] a_re, a_im, b_re, b_im;

    logic       ready1, valid1, last1, busy1, ovf1;
    logic [7:0] data1;
    logic       ready3, valid3, last3, busy3, ovf3;
    logic [7:0] data3;

    always #5 clk = ~clk;

    task_8_result_serializer dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(vin),
        .i_A_re(a_re), .i_A_im(a_im), .i_B_re(b_re), .i_B_im(b_im),
        .o_ready(ready1), .o_data(data1), .o_valid(valid1), .i_ready(rdy),
        .o_last(last1), .o_busy(busy1), .o_overflow(ovf1)
    );

    task_8_result_serializer #(.FIFO_DEPTH(2), .RESULTS_PER_PACKET(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_valid(vin),
        .i_A_re(a_re), .i_A_im(a_im), .i_B_re(b_re), .i_B_im(b_im),
        .o_ready(ready3), .o_data(data3), .o_valid(valid3), .i_ready(rdy),
        .o_last(last3), .o_busy(busy3), .o_overflow(ovf3)
    );

    int total = 0;
    int bad   = 0;

    // reference model: queue of pending results, byte position in head, results completed
    logic [127:0] q[$];
    int           bidx;
    int           nres;
    bit           ready_m;
    bit           ovf_m;
    bit           after_rst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit           ev;
        logic [127:0] h;
        ev = (q.size() > 0);
        chk("ready", ready1, ready_m);
        chk("valid", valid1, ev);
        chk("busy", busy1, ev);
        chk("overflow", ovf1, ovf_m);
        chk("last_p1", last1, ev && bidx == 15);
        chk("valid_p3", valid3, ev);
        chk("last_p3", last3, ev && bidx == 15 && (nres % 3) == 2);
        if (ev) begin
            h = q[0];
            chk("data", data1, h[127 - 8*bidx -: 8]);
            chk("data_p3", data3, h[127 - 8*bidx -: 8]);
        end else if (after_rst) begin
            chk("data_rst", data1, 0);
        end
    endtask

    task automatic model_edge();
        bit push, pop;
        if (rst) begin
            q.delete();
            bidx    = 0;
            nres    = 0;
            ready_m = 0;
            ovf_m   = 0;
        end else begin
            push = vin && ready_m;
            pop  = (q.size() > 0) && rdy && bidx == 15;
            if (vin && !ready_m) ovf_m = 1;
            if (q.size() > 0 && rdy) begin
                if (bidx == 15) begin
                    bidx = 0;
                    nres++;
                end else begin
                    bidx++;
                end
            end
            if (pop)  void'(q.pop_front());
            if (push) q.push_back({a_re, a_im, b_re, b_im});
            ready_m = (q.size() < DEPTH);
        end
        after_rst = rst;
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_data();
        a_re = $urandom;
        a_im = $urandom;
        b_re = $urandom;
        b_im = $urandom;
    endtask

    task automatic do_reset();
        rst = 1;
        vin = 0;
        tick();
        rst = 0;
    endtask

    initial begin
        rst = 1; vin = 0; rdy = 0;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0;
        @(posedge clk);
        model_edge();
        #1;
        tick();
        rst = 0;
        tick();
        tick();

        // single known result, downstream always ready
        a_re = 32'h11223344; a_im = 32'h55667788; b_re = 32'h99AABBCC; b_im = 32'hDDEEFF00;
        vin = 1; rdy = 1;
        tick();
        vin = 0;
        repeat (18) tick();

        // same result with downstream ready toggling every cycle
        vin = 1;
        tick();
        vin = 0;
        for (int i = 0; i < 36; i++) begin
            rdy = (i % 2 == 0);
            tick();
        end

        // three back-to-back results while stalled: third one overflows
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            rnd_data();
            vin = 1;
            tick();
        end
        vin = 0;
        tick();
        rdy = 1;
        repeat (36) tick();

        // streaming as fast as the FIFO allows, packet framing over several results
        do_reset();
        rdy = 1;
        for (int i = 0; i < 110; i++) begin
            rnd_data();
            vin = ready_m;
            tick();
        end
        vin = 0;
        repeat (40) tick();

        // refill to full, then accept on the same edge as the head's last byte
        do_reset();
        tick();
        rdy = 0;
        for (int i = 0; i < 2; i++) begin
            rnd_data();
            vin = 1;
            tick();
        end
        vin = 0;
        rdy = 1;
        for (int i = 0; i < 40; i++) begin
            rnd_data();
            vin = (q.size() == 1 && bidx == 15);
            tick();
        end
        vin = 0;
        repeat (20) tick();

        // reset in the middle of a result
        do_reset();
        tick();
        rnd_data();
        vin = 1; rdy = 1;
        tick();
        vin = 0;
        for (int i = 0; i < 20 && bidx != 7; i++) tick();
        chk("reached_byte7", bidx, 7);
        rst = 1;
        tick();
        rst = 0;
        tick();
        rnd_data();
        vin = 1;
        tick();
        vin = 0;
        repeat (18) tick();

        // random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            vin = $urandom_range(0, 1);
            rdy = ($urandom_range(0, 3) != 0);
            rnd_data();
            tick();
        end
        rst = 0; vin = 0; rdy = 1;
        repeat (40) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
